// File: rtl/mvu_seq_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mvu_seq_accumulator
// Purpose  : Per-lane signed accumulation of the replay-buffer stream. Each
//            sequence, terminated by ilast, yields one PE-wide result word.
//            The final-repetition flag travels with that result.
// Revision : 1.0 - initial release
// ============================================================================
module mvu_seq_accumulator #(
    parameter int PE = 4,
    parameter int IW = 8,
    parameter int OW = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PE*IW-1:0] idat,
    input  logic             ilast,
    input  logic             ifin,
    input  logic             ivld,
    output logic             irdy,
    output logic [PE*OW-1:0] odat,
    output logic             ofin,
    output logic             ovld,
    input  logic             ordy
);

    // Reject parameter sets that cannot describe a meaningful datapath.
    if (OW < IW || PE == 0 || IW == 0) begin : g_bad_params
        $error("mvu_seq_accumulator: illegal parameters PE=%0d IW=%0d OW=%0d", PE, IW, OW);
    end

    logic w_accept;
    logic w_load_out;
    logic r_first;
    logic r_ovld;
    logic r_ofin;

    // Non-last beats touch only the accumulators, so only a last beat can be
    // held off, and only while the single output entry cannot be freed.
    assign irdy       = !ilast || !r_ovld || ordy;
    assign w_accept   = ivld && irdy;
    assign w_load_out = w_accept && ilast;

    assign ovld = r_ovld;
    assign ofin = r_ofin;

    // First marks the opening beat of a sequence; it masks the stale
    // accumulator so no explicit clear is needed between sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 1'b1;
        end else if (w_accept) begin
            r_first <= ilast;
        end
    end

    // One-entry output register: a new result reloads it even while the
    // previous one is being consumed, sustaining one result per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovld <= 1'b0;
            r_ofin <= 1'b0;
        end else if (w_load_out) begin
            r_ovld <= 1'b1;
            r_ofin <= ifin;
        end else if (r_ovld && ordy) begin
            r_ovld <= 1'b0;
        end
    end

    for (genvar i = 0; i < PE; i++) begin : g_lane
        logic [IW-1:0]    w_lane;
        logic [OW+IW-1:0] w_ext;
        logic [OW-1:0]    w_x;
        logic [OW-1:0]    w_sum;
        logic [OW-1:0]    r_acc;
        logic [OW-1:0]    r_out;

        // Sign-extend the lane; the extra IW bits keep this legal when OW == IW.
        assign w_lane = idat[i*IW +: IW];
        assign w_ext  = {{OW{w_lane[IW-1]}}, w_lane};
        assign w_x    = w_ext[OW-1:0];
        // Modulo-2^OW sum: overflow wraps, no saturation.
        assign w_sum  = (r_first ? '0 : r_acc) + w_x;

        assign odat[i*OW +: OW] = r_out;

        // Running partial sum; left untouched by the last beat since First
        // masks it on the next sequence anyway.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc <= '0;
            end else if (w_accept && !ilast) begin
                r_acc <= w_sum;
            end
        end

        // Result lane captured on the last beat and held until replaced.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= '0;
            end else if (w_load_out) begin
                r_out <= w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvu_seq_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_seq_accumulator
// Purpose  : Directed self-checking bench for mvu_seq_accumulator, plus a
//            narrow OW == IW instance for the wrap-around case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvu_seq_accumulator;

    localparam int PE = 4;
    localparam int IW = 8;
    localparam int OW = 24;

    logic             clk;
    logic             rst;
    logic [PE*IW-1:0] idat;
    logic             ilast;
    logic             ifin;
    logic             ivld;
    logic             irdy;
    logic [PE*OW-1:0] odat;
    logic             ofin;
    logic             ovld;
    logic             ordy;

    // Narrow instance: PE=1, IW=OW=8
    logic [7:0] n_idat;
    logic       n_ilast;
    logic       n_ifin;
    logic       n_ivld;
    logic       n_irdy;
    logic [7:0] n_odat;
    logic       n_ofin;
    logic       n_ovld;
    logic       n_ordy;

    int n_checks = 0;
    int n_err    = 0;

    mvu_seq_accumulator #(.PE(PE), .IW(IW), .OW(OW)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .idat  (idat),
        .ilast (ilast),
        .ifin  (ifin),
        .ivld  (ivld),
        .irdy  (irdy),
        .odat  (odat),
        .ofin  (ofin),
        .ovld  (ovld),
        .ordy  (ordy)
    );

    mvu_seq_accumulator #(.PE(1), .IW(8), .OW(8)) u_wrap (
        .clk   (clk),
        .rst   (rst),
        .idat  (n_idat),
        .ilast (n_ilast),
        .ifin  (n_ifin),
        .ivld  (n_ivld),
        .irdy  (n_irdy),
        .odat  (n_odat),
        .ofin  (n_ofin),
        .ovld  (n_ovld),
        .ordy  (n_ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
        logic [31:0] r;
        r = {d[7:0], c[7:0], b[7:0], a[7:0]};
        return r;
    endfunction

    task automatic drive(input logic [31:0] d, input logic l, input logic f);
        idat  = d;
        ilast = l;
        ifin  = f;
        ivld  = 1'b1;
    endtask

    initial begin
        rst = 1'b1; idat = '0; ilast = 1'b0; ifin = 1'b0; ivld = 1'b0; ordy = 1'b1;
        n_idat = '0; n_ilast = 1'b0; n_ifin = 1'b0; n_ivld = 1'b0; n_ordy = 1'b1;
        step(); step();
        chk("reset_ovld", ovld, 1'b0);
        chk("reset_odat", odat, 96'h0);
        chk("reset_ofin", ofin, 1'b0);
        rst = 1'b0;
        step();
        chk("idle_ovld", ovld, 1'b0);
        chk("idle_irdy", irdy, 1'b1);

        // 1) four-beat sequence; lane0 1..4, lane1 -1 each, lane2 10..40, lane3 0
        drive(p4(1, -1, 10, 0), 1'b0, 1'b0); step();
        chk("seq1_no_early_vld_a", ovld, 1'b0);
        drive(p4(2, -1, 20, 0), 1'b0, 1'b1); step();
        chk("seq1_no_early_vld_b", ovld, 1'b0);
        drive(p4(3, -1, 30, 0), 1'b0, 1'b0); step();
        chk("seq1_no_early_vld_c", ovld, 1'b0);
        drive(p4(4, -1, 40, 0), 1'b1, 1'b0); step();
        ivld = 1'b0;
        chk("seq1_ovld", ovld, 1'b1);
        chk("seq1_odat", odat, {24'd0, 24'd100, 24'hFFFFFC, 24'd10});
        chk("seq1_ofin", ofin, 1'b0);
        step();
        chk("seq1_single_pulse", ovld, 1'b0);

        // 2) negative lanes: -128 + -1 + 5 = -124
        drive(p4(-128, 0, 0, 0), 1'b0, 1'b0); step();
        drive(p4(-1, 0, 0, 0), 1'b0, 1'b0); step();
        drive(p4(5, 0, 0, 0), 1'b1, 1'b0); step();
        ivld = 1'b0;
        chk("neg_ovld", ovld, 1'b1);
        chk("neg_odat", odat, {72'h0, 24'hFFFF84});
        step();

        // 3) back-to-back single-beat sequences
        drive(p4(7, 0, 0, 0), 1'b1, 1'b0); step();
        chk("b2b_vld_7", ovld, 1'b1);
        chk("b2b_dat_7", odat, {72'h0, 24'd7});
        chk("b2b_fin_7", ofin, 1'b0);
        drive(p4(8, 0, 0, 0), 1'b1, 1'b0); step();
        chk("b2b_vld_8", ovld, 1'b1);
        chk("b2b_dat_8", odat, {72'h0, 24'd8});
        chk("b2b_fin_8", ofin, 1'b0);
        drive(p4(9, 0, 0, 0), 1'b1, 1'b1); step();
        ivld = 1'b0;
        chk("b2b_vld_9", ovld, 1'b1);
        chk("b2b_dat_9", odat, {72'h0, 24'd9});
        chk("b2b_fin_9", ofin, 1'b1);
        step();
        chk("b2b_drain", ovld, 1'b0);

        // 4) backpressure: result 2 held while the next sequence streams in
        ordy = 1'b0;
        drive(p4(1, 0, 0, 0), 1'b0, 1'b0); step();
        drive(p4(1, 0, 0, 0), 1'b1, 1'b0); step();
        chk("bp_first_vld", ovld, 1'b1);
        chk("bp_first_dat", odat, {72'h0, 24'd2});
        drive(p4(10, 0, 0, 0), 1'b0, 1'b0); #1;
        chk("bp_nonlast_rdy_a", irdy, 1'b1);
        step();
        drive(p4(20, 0, 0, 0), 1'b0, 1'b1); #1;
        chk("bp_nonlast_rdy_b", irdy, 1'b1);
        step();
        drive(p4(30, 0, 0, 0), 1'b1, 1'b1); #1;
        chk("bp_last_stall", irdy, 1'b0);
        step();
        chk("bp_hold_vld", ovld, 1'b1);
        chk("bp_hold_dat", odat, {72'h0, 24'd2});
        chk("bp_hold_fin", ofin, 1'b0);
        chk("bp_still_stalled", irdy, 1'b0);
        ordy = 1'b1; #1;
        chk("bp_release_rdy", irdy, 1'b1);
        step();
        ivld = 1'b0;
        chk("bp_second_vld", ovld, 1'b1);
        chk("bp_second_dat", odat, {72'h0, 24'd60});
        chk("bp_second_fin", ofin, 1'b1);
        step();
        chk("bp_drain", ovld, 1'b0);

        // 5) reset drops a pending result and a partial sum
        ordy = 1'b0;
        drive(p4(50, 0, 0, 0), 1'b1, 1'b0); step();
        chk("rst_pending_vld", ovld, 1'b1);
        drive(p4(100, 0, 0, 0), 1'b0, 1'b0); step();
        drive(p4(100, 0, 0, 0), 1'b0, 1'b0); step();
        ivld = 1'b0;
        rst  = 1'b1;
        step();
        chk("rst_during_vld", ovld, 1'b0);
        chk("rst_during_dat", odat, 96'h0);
        rst = 1'b0;
        step();
        chk("rst_after_vld", ovld, 1'b0);
        ordy = 1'b1;
        drive(p4(3, 0, 0, 0), 1'b0, 1'b0); step();
        drive(p4(4, 0, 0, 0), 1'b1, 1'b0); step();
        ivld = 1'b0;
        chk("rst_fresh_vld", ovld, 1'b1);
        chk("rst_fresh_dat", odat, {72'h0, 24'd7});
        step();

        // 6) wrap with OW == IW == 8: 127 + 1 -> 8'h80
        n_idat = 8'd127; n_ilast = 1'b0; n_ivld = 1'b1; step();
        n_idat = 8'd1;   n_ilast = 1'b1; step();
        n_ivld = 1'b0;
        chk("wrap_vld", n_ovld, 1'b1);
        chk("wrap_dat", n_odat, 8'h80);
        chk("wrap_fin", n_ofin, 1'b0);
        step();
        chk("wrap_drain", n_ovld, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
